// File: rtl/block_mem_responder.sv
// block_mem_responder: 512-bit block memory that completes each read/write
// after LATENCY cycles with a one-cycle mem_ready pulse.
module block_mem_responder #(
    parameter int BLOCK_ADDR_WIDTH = 8,
    parameter int LATENCY          = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_addr,
    input  logic [511:0] mem_write_data,
    output logic [511:0] mem_read_data,
    output logic         mem_ready,
    output logic         busy,
    output logic         err_protocol
);
    if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
        $error("block_mem_responder: LATENCY must be in 1..255");
    end

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                      r_state;
    logic [7:0]                  r_cnt;
    logic                        r_op_wr;
    logic [BLOCK_ADDR_WIDTH-1:0] r_idx;
    logic [511:0]                r_wdata;
    logic [511:0]                r_mem [2**BLOCK_ADDR_WIDTH];
    logic                        w_strobe;
    logic                        w_last;
    logic                        w_unused_addr;

    assign w_strobe      = mem_read | mem_write;
    assign w_last        = (r_state == WAIT) && (r_cnt == 8'd0);
    assign w_unused_addr = ^{mem_addr[31:BLOCK_ADDR_WIDTH+6], mem_addr[5:0]};

    // Array has no reset so it can map onto block RAM; rst gates the commit.
    always_ff @(posedge clk) begin
        if (rst && w_last && r_op_wr)
            r_mem[r_idx] <= r_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_cnt         <= 8'd0;
            r_op_wr       <= 1'b0;
            r_idx         <= '0;
            r_wdata       <= '0;
            mem_read_data <= '0;
            mem_ready     <= 1'b0;
            busy          <= 1'b0;
            err_protocol  <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            if (w_strobe && (r_state == WAIT || (mem_read && mem_write)))
                err_protocol <= 1'b1;
            case (r_state)
                IDLE, DONE: begin
                    // DONE accepts like IDLE so back-to-back strobes are served
                    if (w_strobe) begin
                        r_op_wr <= mem_write;
                        r_idx   <= mem_addr[BLOCK_ADDR_WIDTH+5:6];
                        if (mem_write)
                            r_wdata <= mem_write_data;
                        r_cnt   <= 8'(LATENCY - 1);
                        busy    <= 1'b1;
                        r_state <= WAIT;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                WAIT: begin
                    if (r_cnt == 8'd0) begin
                        r_state   <= DONE;
                        mem_ready <= 1'b1;
                        if (!r_op_wr)
                            mem_read_data <= r_mem[r_idx];
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_block_mem_responder.sv
// tb_block_mem_responder: directed tests against a transaction-time model
// of the block memory responder.
module tb_block_mem_responder;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read, mem_write;
    logic [31:0]  mem_addr;
    logic [511:0] mem_write_data;
    logic [511:0] mem_read_data;
    logic         mem_ready, busy, err_protocol;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    block_mem_responder #(.BLOCK_ADDR_WIDTH(8), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_ready(mem_ready),
        .busy(busy), .err_protocol(err_protocol)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: each accepted transfer completes at edge (accept + LAT); any
    // strobe while a transfer is outstanding up to that edge is an error.
    logic [511:0] mm [256];
    int           cyc = 0, done_e = 0, m_idx = 0;
    bit           act = 0, m_wr = 0;
    logic [511:0] m_wd = '0;
    logic         exp_ready = 0, exp_busy = 0, exp_err = 0;
    logic [511:0] exp_rdata = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            act = 0; cyc = 0;
            exp_ready = 0; exp_busy = 0; exp_err = 0; exp_rdata = '0;
        end else begin
            cyc++;
            exp_ready = act && cyc == done_e;
            if (exp_ready) begin
                if (m_wr) mm[m_idx] = m_wd;
                else      exp_rdata = mm[m_idx];
            end
            if (act && cyc > done_e) act = 0;
            if (mem_read || mem_write) begin
                if (act) exp_err = 1;
                else begin
                    act = 1; done_e = cyc + LAT; m_wr = mem_write;
                    m_idx = int'(mem_addr[13:6]); m_wd = mem_write_data;
                    if (mem_read && mem_write) exp_err = 1;
                end
            end
            exp_busy = act;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ready", 512'(mem_ready), 512'(exp_ready));
            chk("cyc_busy", 512'(busy), 512'(exp_busy));
            chk("cyc_err", 512'(err_protocol), 512'(exp_err));
            chk("cyc_rdata", mem_read_data, exp_rdata);
        end
    end

    task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [511:0] d);
        mem_read = rd; mem_write = wr; mem_addr = a; mem_write_data = d;
    endtask

    task automatic idle();
        drive(0, 0, 32'($urandom), {16{32'($urandom)}});
    endtask

    logic [511:0] last_rd;

    // First strobe at i=0, optional second strobe at i=k; counts over 16 cycles.
    task automatic xfer(input bit rd1, input bit wr1, input logic [31:0] a1, input logic [511:0] d1,
                        input int k, input bit rd2, input bit wr2, input logic [31:0] a2,
                        input logic [511:0] d2, output int lat, output int bc, output int rc);
        lat = -1; bc = 0; rc = 0;
        @(negedge clk);
        drive(rd1, wr1, a1, d1);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                rc++;
                if (lat < 0) lat = i;
                last_rd = mem_read_data;
            end
            if (busy) bc++;
            if (i == k) drive(rd2, wr2, a2, d2);
            else idle();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
    endtask

    localparam logic [31:0] A = 32'h0000_1040, B = 32'h0000_2000, C = 32'h0000_3000;
    localparam logic [31:0] D = 32'h0000_4000, E = 32'h0000_5000;
    localparam logic [511:0] DB  = {16{32'hDEAD_BEEF}};
    localparam logic [511:0] P   = {16{32'h0123_4567}};
    localparam logic [511:0] Q   = {16{32'hCAFE_F00D}};
    localparam logic [511:0] BB  = {16{32'hB0B0_B0B0}};
    localparam logic [511:0] V55 = {64{8'h55}};
    localparam logic [511:0] V11 = {64{8'h11}};
    localparam logic [511:0] V22 = {64{8'h22}};
    localparam logic [511:0] VE  = {16{32'h600D_CAFE}};

    int lat, bc, rc;

    initial begin
        rst = 0;
        drive(0, 0, 0, '0);
        repeat (3) @(negedge clk);
        chk("rst_ready", 512'(mem_ready), 0);
        chk("rst_busy", 512'(busy), 0);
        chk("rst_err", 512'(err_protocol), 0);
        chk("rst_rdata", mem_read_data, 0);
        rst = 1;
        chk_en = 1;

        xfer(0, 1, A, DB, 0, 0, 0, 0, 0, lat, bc, rc);
        chk("wrA_lat", 512'(lat), 5);
        chk("wrA_busy", 512'(bc), 5);
        chk("wrA_ready", 512'(rc), 1);
        chk("wrA_err", 512'(err_protocol), 0);

        xfer(1, 0, A, '0, 0, 0, 0, 0, 0, lat, bc, rc);
        chk("rdA_lat", 512'(lat), 5);
        chk("rdA_data", last_rd, DB);
        repeat (10) @(negedge clk);
        chk("rdA_hold", mem_read_data, DB);

        xfer(0, 1, 32'h0004_0040, P, 0, 0, 0, 0, 0, lat, bc, rc);
        xfer(1, 0, 32'h0000_0040, '0, 0, 0, 0, 0, 0, lat, bc, rc);
        chk("alias_data", last_rd, P);
        xfer(1, 0, 32'h0000_007C, '0, 0, 0, 0, 0, 0, lat, bc, rc);
        chk("offset_data", last_rd, P);

        xfer(0, 1, B, BB, 0, 0, 0, 0, 0, lat, bc, rc);
        xfer(0, 1, A, Q, 2, 1, 0, B, '0, lat, bc, rc);
        chk("wait_strobe_ready", 512'(rc), 1);
        chk("wait_strobe_err", 512'(err_protocol), 1);
        chk("wait_strobe_rdata", mem_read_data, P);
        xfer(1, 0, A, '0, 0, 0, 0, 0, 0, lat, bc, rc);
        chk("wait_A_data", last_rd, Q);
        xfer(1, 0, B, '0, 0, 0, 0, 0, 0, lat, bc, rc);
        chk("wait_B_data", last_rd, BB);
        chk("err_sticky", 512'(err_protocol), 1);

        do_reset();
        chk("rst2_err", 512'(err_protocol), 0);
        xfer(1, 1, C, V55, 0, 0, 0, 0, 0, lat, bc, rc);
        chk("both_lat", 512'(lat), 5);
        chk("both_err", 512'(err_protocol), 1);
        xfer(1, 0, C, '0, 0, 0, 0, 0, 0, lat, bc, rc);
        chk("both_C_data", last_rd, V55);

        do_reset();
        xfer(0, 1, D, V11, 0, 0, 0, 0, 0, lat, bc, rc);
        @(negedge clk);
        drive(0, 1, D, V22);
        @(negedge clk);
        idle();
        @(negedge clk);
        #2 rst = 0;
        #1;
        chk("abort_busy", 512'(busy), 0);
        chk("abort_ready", 512'(mem_ready), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        xfer(1, 0, D, '0, 0, 0, 0, 0, 0, lat, bc, rc);
        chk("abort_D_data", last_rd, V11);
        @(negedge clk);
        drive(1, 0, D, '0);
        @(negedge clk);
        idle();
        @(negedge clk);
        #2 rst = 0;
        @(negedge clk);
        chk("abort_rd_rdata", mem_read_data, 0);
        @(negedge clk);
        rst = 1;

        xfer(0, 1, E, VE, 5, 1, 0, E, '0, lat, bc, rc);
        chk("b2b_lat", 512'(lat), 5);
        chk("b2b_ready", 512'(rc), 2);
        chk("b2b_busy", 512'(bc), 10);
        chk("b2b_data", last_rd, VE);
        chk("b2b_err", 512'(err_protocol), 0);

        repeat (2) @(negedge clk);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
